// File: rtl/exec_wb_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus a 16-step shift-add multiply,
// driving the register-file write port for one cycle and keeping NZCV status.
module exec_wb_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [AW-1:0]    DST,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRV,
  output logic [AW-1:0]    WADDR,
  output logic [WIDTH-1:0] WDATA,
  output logic [3:0]       FLAGS
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_CMP = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WB
  } state_e;

  state_e             state;
  op_e                op_q;
  logic [AW-1:0]      dst_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // One shift-add step: the multiplier sits in the low half of acc and is consumed LSB first.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result;
  logic             c_flag;
  logic             v_flag;
  logic             flag_upd;
  logic             writes;
  logic [3:0]       flags_nxt;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    result   = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    flag_upd = 1'b0;
    writes   = 1'b0;
    case (op_q)
      OP_MOV: begin
        result = b_q;
        writes = 1'b1;
      end
      OP_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        c_flag   = sum_ext[WIDTH];
        v_flag   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
        flag_upd = 1'b1;
        writes   = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        result   = diff_ext[WIDTH-1:0];
        c_flag   = ~diff_ext[WIDTH];
        v_flag   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
        flag_upd = 1'b1;
        writes   = (op_q == OP_SUB);
      end
      OP_AND: begin
        result   = a_q & b_q;
        flag_upd = 1'b1;
        writes   = 1'b1;
      end
      OP_XOR: begin
        result   = a_q ^ b_q;
        flag_upd = 1'b1;
        writes   = 1'b1;
      end
      OP_MUL: begin
        result   = acc[WIDTH-1:0];
        c_flag   = |acc[2*WIDTH-1:WIDTH];
        flag_upd = 1'b1;
        writes   = 1'b1;
      end
      default: ;
    endcase
    flags_nxt = flag_upd ? {result[WIDTH-1], (result == '0), c_flag, v_flag} : FLAGS;
  end

  // NOTE: sequential state uses non-blocking assignments; RST is synchronous, so it is checked inside the clocked block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      op_q  <= OP_MOV;
      dst_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      WRV   <= 1'b0;
      WADDR <= '0;
      WDATA <= '0;
      FLAGS <= 4'b0000;
    end else begin
      DONE <= 1'b0;
      WRV  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            op_q  <= op_e'(OP);
            dst_q <= DST;
            a_q   <= SRC_A;
            b_q   <= SRC_B;
            acc   <= {{WIDTH{1'b0}}, SRC_B};
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= (op_e'(OP) == OP_MUL) ? S_MUL : S_WB;
          end
        end
        S_MUL: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_WB;
        end
        S_WB: begin
          // r0 is hard-wired to zero in the register file, so its writes are dropped here.
          DONE  <= 1'b1;
          WRV   <= writes && (dst_q != '0);
          WADDR <= dst_q;
          WDATA <= result;
          FLAGS <= flags_nxt;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
